// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses, cause codes,
// FSM state encoding and the cause/target helpers.
package trap_sequencer_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [11:0] CsrMepc   = 12'h341;
  localparam logic [11:0] CsrMcause = 12'h342;
  localparam logic [11:0] CsrMtval  = 12'h343;

  localparam logic [3:0] CauseMei     = 4'd11;
  localparam logic [3:0] CauseMsi     = 4'd3;
  localparam logic [3:0] CauseMti     = 4'd7;
  localparam logic [3:0] CauseIllegal = 4'd2;
  localparam logic [3:0] CauseEcall   = 4'd11;
  localparam logic [3:0] CauseEbreak  = 4'd3;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSaveEpc   = 3'd1,
    StSaveCause = 3'd2,
    StSaveTval  = 3'd3,
    StRedirect  = 3'd4,
    StRet       = 3'd5
  } state_e;

  function automatic logic [XLEN-1:0] make_cause(input logic is_irq, input logic [3:0] code);
    return {is_irq, {(XLEN - 5){1'b0}}, code};
  endfunction

  // Vectored mode only applies to interrupts; the add wraps at XLEN bits.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic            is_irq,
                                                  input logic [3:0]      code);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (is_irq && (mtvec[1:0] == 2'b01)) begin
      return base + {{(XLEN - 6){1'b0}}, code, 2'b00};
    end
    return base;
  endfunction

endpackage

// File: rtl/trap_priority_encoder.sv
// Fixed-priority select over pending interrupts and synchronous exceptions.
module trap_priority_encoder
  import trap_sequencer_pkg::*;
(
  input  logic       mei_in,
  input  logic       msi_in,
  input  logic       mti_in,
  input  logic       illegal_in,
  input  logic       ecall_in,
  input  logic       ebreak_in,
  output logic       valid_out,
  output logic       is_interrupt_out,
  output logic [3:0] code_out
);

  always_comb begin
    valid_out        = 1'b1;
    is_interrupt_out = 1'b0;
    code_out         = 4'd0;
    if (mei_in) begin
      is_interrupt_out = 1'b1;
      code_out         = CauseMei;
    end else if (msi_in) begin
      is_interrupt_out = 1'b1;
      code_out         = CauseMsi;
    end else if (mti_in) begin
      is_interrupt_out = 1'b1;
      code_out         = CauseMti;
    end else if (illegal_in) begin
      code_out = CauseIllegal;
    end else if (ecall_in) begin
      code_out = CauseEcall;
    end else if (ebreak_in) begin
      code_out = CauseEbreak;
    end else begin
      valid_out = 1'b0;
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Trap-entry / mret controller: arbitrates traps, stalls the core, serialises the
// mepc/mcause/mtval writes through the CSR write port and redirects the PC.
module trap_sequencer
  import trap_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            illegal_instr_in,
  input  logic            ecall_in,
  input  logic            ebreak_in,
  input  logic            mret_in,
  input  logic            ext_irq_in,
  input  logic            sw_irq_in,
  input  logic            tmr_irq_in,
  input  logic            mstatus_mie_in,
  input  logic [XLEN-1:0] mie_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  output logic            stall_out,
  output logic            csr_we_out,
  output logic [11:0]     csr_waddr_out,
  output logic [XLEN-1:0] csr_wdata_out,
  output logic            pc_redirect_out,
  output logic [XLEN-1:0] pc_target_out,
  output logic            trap_entry_out,
  output logic            mret_out
);

  state_e          state_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] target_q;

  logic       mei_pend, msi_pend, mti_pend;
  logic       enc_valid, enc_irq;
  logic [3:0] enc_code;
  logic       idle, trap_take, mret_take;

  assign mei_pend = ext_irq_in & mie_in[11] & mstatus_mie_in;
  assign msi_pend = sw_irq_in & mie_in[3] & mstatus_mie_in;
  assign mti_pend = tmr_irq_in & mie_in[7] & mstatus_mie_in;

  trap_priority_encoder u_prio (
    .mei_in           (mei_pend),
    .msi_in           (msi_pend),
    .mti_in           (mti_pend),
    .illegal_in       (illegal_instr_in),
    .ecall_in         (ecall_in),
    .ebreak_in        (ebreak_in),
    .valid_out        (enc_valid),
    .is_interrupt_out (enc_irq),
    .code_out         (enc_code)
  );

  assign idle      = (state_q == StIdle);
  assign trap_take = idle & instr_valid_in & enc_valid;
  assign mret_take = idle & instr_valid_in & mret_in & ~enc_valid;

  // Gated by reset so every output is low while reset is held.
  assign stall_out = reset & (~idle | trap_take | mret_take);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      cause_q         <= '0;
      target_q        <= '0;
      csr_we_out      <= 1'b0;
      csr_waddr_out   <= '0;
      csr_wdata_out   <= '0;
      pc_redirect_out <= 1'b0;
      pc_target_out   <= '0;
      trap_entry_out  <= 1'b0;
      mret_out        <= 1'b0;
    end else begin
      csr_we_out      <= 1'b0;
      csr_waddr_out   <= '0;
      csr_wdata_out   <= '0;
      pc_redirect_out <= 1'b0;
      pc_target_out   <= '0;
      trap_entry_out  <= 1'b0;
      mret_out        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (trap_take) begin
            // The registered mepc write data doubles as the PC latch.
            state_q       <= StSaveEpc;
            cause_q       <= make_cause(enc_irq, enc_code);
            target_q      <= trap_target(mtvec_in, enc_irq, enc_code);
            csr_we_out    <= 1'b1;
            csr_waddr_out <= CsrMepc;
            csr_wdata_out <= {pc_in[XLEN-1:2], 2'b00};
          end else if (mret_take) begin
            state_q         <= StRet;
            pc_redirect_out <= 1'b1;
            pc_target_out   <= {mepc_in[XLEN-1:2], 2'b00};
            mret_out        <= 1'b1;
          end
        end
        StSaveEpc: begin
          state_q       <= StSaveCause;
          csr_we_out    <= 1'b1;
          csr_waddr_out <= CsrMcause;
          csr_wdata_out <= cause_q;
        end
        StSaveCause: begin
          state_q       <= StSaveTval;
          csr_we_out    <= 1'b1;
          csr_waddr_out <= CsrMtval;
        end
        StSaveTval: begin
          state_q         <= StRedirect;
          pc_redirect_out <= 1'b1;
          pc_target_out   <= target_q;
          trap_entry_out  <= 1'b1;
        end
        StRedirect: state_q <= StIdle;
        StRet:      state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{mie_in[XLEN-1:12], mie_in[10:8], mie_in[6:4], mie_in[2:0],
                         mepc_in[1:0], pc_in[1:0]};

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: a vector table of single-instruction scenarios
// plus hand-written sequences for mid-sequence input changes, reset abort and back-to-back traps.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid_in;
  logic [31:0] pc_in;
  logic        illegal_instr_in, ecall_in, ebreak_in, mret_in;
  logic        ext_irq_in, sw_irq_in, tmr_irq_in, mstatus_mie_in;
  logic [31:0] mie_in, mtvec_in, mepc_in;
  logic        stall_out, csr_we_out;
  logic [11:0] csr_waddr_out;
  logic [31:0] csr_wdata_out;
  logic        pc_redirect_out;
  logic [31:0] pc_target_out;
  logic        trap_entry_out, mret_out;

  trap_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .instr_valid_in   (instr_valid_in),
    .pc_in            (pc_in),
    .illegal_instr_in (illegal_instr_in),
    .ecall_in         (ecall_in),
    .ebreak_in        (ebreak_in),
    .mret_in          (mret_in),
    .ext_irq_in       (ext_irq_in),
    .sw_irq_in        (sw_irq_in),
    .tmr_irq_in       (tmr_irq_in),
    .mstatus_mie_in   (mstatus_mie_in),
    .mie_in           (mie_in),
    .mtvec_in         (mtvec_in),
    .mepc_in          (mepc_in),
    .stall_out        (stall_out),
    .csr_we_out       (csr_we_out),
    .csr_waddr_out    (csr_waddr_out),
    .csr_wdata_out    (csr_wdata_out),
    .pc_redirect_out  (pc_redirect_out),
    .pc_target_out    (pc_target_out),
    .trap_entry_out   (trap_entry_out),
    .mret_out         (mret_out)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // kind: 0 = no action, 1 = trap, 2 = mret
  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] pc;
    logic [3:0]  exc;   // {illegal, ecall, ebreak, mret}
    logic [2:0]  irq;   // {ext, sw, tmr}
    logic        gmie;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    int          kind;
    logic [31:0] cause;
    logic [31:0] target;
    logic [31:0] epc;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input string n, input logic v, input logic [31:0] pc,
                              input logic [3:0] exc, input logic [2:0] irq, input logic gmie,
                              input logic [31:0] mie, input logic [31:0] mtvec,
                              input logic [31:0] mepc, input int kind,
                              input logic [31:0] cause, input logic [31:0] target,
                              input logic [31:0] epc);
    vec_t r;
    r.name = n; r.valid = v; r.pc = pc; r.exc = exc; r.irq = irq; r.gmie = gmie;
    r.mie = mie; r.mtvec = mtvec; r.mepc = mepc; r.kind = kind;
    r.cause = cause; r.target = target; r.epc = epc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_valid_in = 0; pc_in = 0;
    illegal_instr_in = 0; ecall_in = 0; ebreak_in = 0; mret_in = 0;
    ext_irq_in = 0; sw_irq_in = 0; tmr_irq_in = 0; mstatus_mie_in = 0;
    mie_in = 0; mtvec_in = 0; mepc_in = 0;
  endtask

  task automatic drive(input vec_t v);
    instr_valid_in = v.valid; pc_in = v.pc;
    {illegal_instr_in, ecall_in, ebreak_in, mret_in} = v.exc;
    {ext_irq_in, sw_irq_in, tmr_irq_in} = v.irq;
    mstatus_mie_in = v.gmie; mie_in = v.mie; mtvec_in = v.mtvec; mepc_in = v.mepc;
  endtask

  function automatic logic any_out();
    return |{stall_out, csr_we_out, csr_waddr_out, csr_wdata_out, pc_redirect_out,
             pc_target_out, trap_entry_out, mret_out};
  endfunction

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1; drive(v);
    @(negedge clk);
    chk({v.name, " stall@T"}, 32'(stall_out), 32'(v.kind != 0));
    chk({v.name, " we@T"}, 32'(csr_we_out), 0);
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    if (v.kind == 1) begin
      chk({v.name, " we@T+1"}, 32'(csr_we_out), 1);
      chk({v.name, " addr@T+1"}, 32'(csr_waddr_out), 32'h341);
      chk({v.name, " mepc"}, csr_wdata_out, v.epc);
      chk({v.name, " stall@T+1"}, 32'(stall_out), 1);
      @(negedge clk);
      chk({v.name, " addr@T+2"}, 32'(csr_waddr_out), 32'h342);
      chk({v.name, " mcause"}, csr_wdata_out, v.cause);
      chk({v.name, " we@T+2"}, 32'(csr_we_out), 1);
      @(negedge clk);
      chk({v.name, " addr@T+3"}, 32'(csr_waddr_out), 32'h343);
      chk({v.name, " mtval"}, csr_wdata_out, 0);
      chk({v.name, " we@T+3"}, 32'(csr_we_out), 1);
      @(negedge clk);
      chk({v.name, " redirect@T+4"}, 32'(pc_redirect_out), 1);
      chk({v.name, " target"}, pc_target_out, v.target);
      chk({v.name, " trap_entry"}, 32'(trap_entry_out), 1);
      chk({v.name, " mret_out@T+4"}, 32'(mret_out), 0);
      chk({v.name, " we@T+4"}, 32'(csr_we_out), 0);
      @(negedge clk);
      chk({v.name, " stall@T+5"}, 32'(stall_out), 0);
      chk({v.name, " redirect@T+5"}, 32'(pc_redirect_out), 0);
    end else if (v.kind == 2) begin
      chk({v.name, " redirect@T+1"}, 32'(pc_redirect_out), 1);
      chk({v.name, " target"}, pc_target_out, v.target);
      chk({v.name, " mret_out"}, 32'(mret_out), 1);
      chk({v.name, " trap_entry"}, 32'(trap_entry_out), 0);
      chk({v.name, " we@T+1"}, 32'(csr_we_out), 0);
      @(negedge clk);
      chk({v.name, " stall@T+2"}, 32'(stall_out), 0);
      chk({v.name, " redirect@T+2"}, 32'(pc_redirect_out), 0);
    end else begin
      chk({v.name, " quiet"}, 32'(any_out()), 0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int redirects;
    vecs[0]  = mk("ecall", 1, 32'h100, 4'b0100, 3'b000, 0, 32'h0, 32'h200, 0,
                  1, 32'h0000000B, 32'h200, 32'h100);
    vecs[1]  = mk("tmr_vec", 1, 32'h400, 4'b0000, 3'b001, 1, 32'h80, 32'h201, 0,
                  1, 32'h80000007, 32'h21C, 32'h400);
    vecs[2]  = mk("tmr_gmie0", 1, 32'h400, 4'b0000, 3'b001, 0, 32'h80, 32'h201, 0,
                  0, 0, 0, 0);
    vecs[3]  = mk("ext_sw_ill", 1, 32'h504, 4'b1000, 3'b110, 1, 32'h888, 32'h301, 0,
                  1, 32'h8000000B, 32'h32C, 32'h504);
    vecs[4]  = mk("mret", 1, 32'h700, 4'b0001, 3'b000, 0, 32'h0, 32'h200, 32'h1236,
                  2, 0, 32'h1234, 0);
    vecs[5]  = mk("mret_sw", 1, 32'h600, 4'b0001, 3'b010, 1, 32'h8, 32'h100, 32'h1236,
                  1, 32'h80000003, 32'h100, 32'h600);
    vecs[6]  = mk("ill_ebreak", 1, 32'h702, 4'b1010, 3'b000, 1, 32'h888, 32'h301, 0,
                  1, 32'h00000002, 32'h300, 32'h700);
    vecs[7]  = mk("mei_wrap", 1, 32'h900, 4'b0000, 3'b100, 1, 32'h800, 32'hFFFFFFF1, 0,
                  1, 32'h8000000B, 32'h0000001C, 32'h900);
    vecs[8]  = mk("ebreak", 1, 32'h800, 4'b0010, 3'b000, 0, 32'h0, 32'h200, 0,
                  1, 32'h00000003, 32'h200, 32'h800);
    vecs[9]  = mk("tmr_masked", 1, 32'h400, 4'b0000, 3'b001, 1, 32'h800, 32'h200, 0,
                  0, 0, 0, 0);
    vecs[10] = mk("ecall_invalid", 0, 32'h100, 4'b0100, 3'b000, 0, 32'h0, 32'h200, 0,
                  0, 0, 0, 0);

    // Reset held with a trap-worthy instruction on the inputs.
    clear_inputs();
    ecall_in = 1; instr_valid_in = 1; pc_in = 32'h100;
    @(posedge clk); #1;
    chk("reset outputs zero", 32'(any_out()), 0);
    clear_inputs();
    @(negedge clk); reset = 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Interrupt lines drop and PC changes mid-sequence; latched cause/PC must hold.
    @(posedge clk); #1;
    drive(vecs[3]);
    @(posedge clk); #1;
    ext_irq_in = 0; sw_irq_in = 0; tmr_irq_in = 1; ecall_in = 1; pc_in = 32'hABC;
    @(negedge clk);
    chk("hold mepc", csr_wdata_out, 32'h504);
    @(negedge clk);
    chk("hold mcause", csr_wdata_out, 32'h8000000B);
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("hold target", pc_target_out, 32'h32C);
    @(negedge clk);
    chk("hold idle", 32'(stall_out), 0);

    // Reset asserted in SAVE_CAUSE.
    @(posedge clk); #1;
    drive(vecs[0]);
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("pre-abort addr", 32'(csr_waddr_out), 32'h342);
    #2 reset = 0;
    #1;
    chk("abort outputs zero", 32'(any_out()), 0);
    @(negedge clk); reset = 1;
    redirects = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pc_redirect_out || stall_out || csr_we_out) redirects++;
    end
    chk("abort no activity", 32'(redirects), 0);

    // Back-to-back: exception detected in the T+5 cycle.
    @(posedge clk); #1;
    drive(vecs[0]);
    @(posedge clk); #1; clear_inputs();
    repeat (4) @(negedge clk);
    chk("b2b first redirect", 32'(pc_redirect_out), 1);
    @(posedge clk); #1;
    instr_valid_in = 1; ebreak_in = 1; pc_in = 32'h200; mtvec_in = 32'h200;
    @(negedge clk);
    chk("b2b stall@T+5", 32'(stall_out), 1);
    chk("b2b redirect cleared", 32'(pc_redirect_out), 0);
    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    chk("b2b second mepc", csr_wdata_out, 32'h200);
    @(negedge clk);
    chk("b2b second mcause", csr_wdata_out, 32'h3);
    repeat (3) @(negedge clk);
    chk("b2b final idle", 32'(stall_out), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
